// File: rtl/player_pkg.sv
// Shared screen geometry and colour codes for the player datapath.
package player_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SHIP_W   = 2;
  localparam int SHIP_H   = 3;

  typedef enum logic [2:0] {
    BLACK = 3'b000,
    WHITE = 3'b111
  } colour_t;

endpackage

// File: rtl/datapath_player_rate_divider.sv
// Free-running frame counter; tick is high for the one cycle in which the count wraps.
module rate_divider #(
  parameter int TICK_CYCLES = 833333,
  parameter int CNT_W       = 20
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n)  cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/datapath_player.sv
// Ship base-row register, clamped move logic, registered VGA pixel pipe and
// frame-tick pacing for the player control FSM.
module datapath_player
  import player_pkg::*;
#(
  parameter logic [7:0] X_BASE      = 8'd4,
  parameter logic [6:0] Y_INIT      = 7'd58,
  parameter logic [6:0] Y_MIN       = 7'd0,
  parameter logic [6:0] Y_MAX       = 7'(SCREEN_H - SHIP_H),
  parameter int         TICK_CYCLES = 833333,
  parameter int         CNT_W       = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       y_pos_mod,
  input  logic       y_neg_mod,
  input  logic       add_x,
  input  logic [1:0] add_y,
  input  logic [2:0] colour_in,
  input  logic       write_en,
  input  logic       continue_draw,
  output logic       draw_enable,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic [6:0] y_base
);

  // The FSM never drives 3, but if it does we stay inside the 3-row ship.
  function automatic logic [1:0] sat_add_y(input logic [1:0] a);
    return (a == 2'd3) ? 2'd2 : a;
  endfunction

  function automatic logic [6:0] clamp_move(input logic [6:0] base,
                                            input logic       up,
                                            input logic       down);
    if (up && !down && base > Y_MIN)      return base - 7'd1;
    else if (down && !up && base < Y_MAX) return base + 7'd1;
    else                                  return base;
  endfunction

  logic       tick;
  logic       pending;
  logic [6:0] y_next_p0;

  rate_divider #(
    .TICK_CYCLES(TICK_CYCLES),
    .CNT_W      (CNT_W)
  ) u_rate_divider (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  assign y_next_p0   = clamp_move(y_base, y_pos_mod, y_neg_mod);
  assign draw_enable = pending & continue_draw;

  // p0 -> p1: base row and pixel outputs; the pixel uses the new base
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      y_base     <= Y_INIT;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
    end else begin
      y_base     <= y_next_p0;
      x_out      <= X_BASE + {7'd0, add_x};
      y_out      <= y_next_p0 + {5'd0, sat_add_y(add_y)};
      colour_out <= colour_in;
      plot       <= write_en;
    end
  end

  // A wrap takes priority over the clear so a tick landing on the clear is kept.
  always_ff @(posedge clk) begin
    if (!reset_n)         pending <= 1'b0;
    else if (tick)        pending <= 1'b1;
    else if (draw_enable) pending <= 1'b0;
  end

endmodule

// File: tb/tb_datapath_player.sv
// Self-checking bench for datapath_player with an 8-cycle frame tick.
module tb_datapath_player;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       y_pos_mod, y_neg_mod, add_x, write_en, continue_draw;
  logic [1:0] add_y;
  logic [2:0] colour_in;
  logic       draw_enable, plot;
  logic [7:0] x_out;
  logic [6:0] y_out, y_base;
  logic [2:0] colour_out;

  datapath_player #(.TICK_CYCLES(8), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .y_pos_mod(y_pos_mod), .y_neg_mod(y_neg_mod),
    .add_x(add_x), .add_y(add_y), .colour_in(colour_in), .write_en(write_en),
    .continue_draw(continue_draw), .draw_enable(draw_enable), .x_out(x_out),
    .y_out(y_out), .colour_out(colour_out), .plot(plot), .y_base(y_base)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int de_seen = 0;

  // Reference model: frame position, ship row, outstanding-tick flag, expected outputs.
  bit m_valid = 0;
  int m_cyc, m_y, m_pend, m_x, m_yo, m_col, m_plot;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_edge();
    int ay;
    bit de, tk;
    if (!reset_n) begin
      m_y = 58; m_x = 0; m_yo = 0; m_col = 0; m_plot = 0; m_pend = 0; m_cyc = 0;
      m_valid = 1;
    end else if (m_valid) begin
      tk = ((m_cyc % 8) == 7);
      de = (m_pend != 0) && continue_draw;
      if (tk) m_pend = 1;
      else if (de) m_pend = 0;
      if (y_pos_mod && !y_neg_mod && m_y > 0) m_y = m_y - 1;
      else if (y_neg_mod && !y_pos_mod && m_y < 117) m_y = m_y + 1;
      ay = (add_y > 2) ? 2 : int'(add_y);
      m_x = 4 + int'(add_x);
      m_yo = m_y + ay;
      m_col = int'(colour_in);
      m_plot = int'(write_en);
      m_cyc++;
    end
  endtask

  // Inputs are already applied; check the combinational pulse, clock once, check registers.
  task automatic step();
    #1;
    if (m_valid) chk("draw_enable", int'(draw_enable), (m_pend != 0 && continue_draw) ? 1 : 0);
    if (draw_enable === 1'b1) de_seen++;
    model_edge();
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("y_base", int'(y_base), m_y);
      chk("x_out", int'(x_out), m_x);
      chk("y_out", int'(y_out), m_yo);
      chk("colour_out", int'(colour_out), m_col);
      chk("plot", int'(plot), m_plot);
    end
  endtask

  task automatic idle_inputs();
    y_pos_mod = 0; y_neg_mod = 0; add_x = 0; add_y = 0; colour_in = 0; write_en = 0;
  endtask

  typedef struct {
    bit       p, n, ax;
    bit [1:0] ay;
    bit [2:0] col;
    bit       we;
    int       yb, x, y, c, pl;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int d0, first_de, gap;
    tbl[0] = '{1, 0, 1, 2'd1, 3'd7, 1, 57, 5, 58, 7, 1};
    tbl[1] = '{0, 1, 0, 2'd2, 3'd3, 1, 58, 4, 60, 3, 1};
    tbl[2] = '{1, 1, 1, 2'd3, 3'd5, 0, 58, 5, 60, 5, 0};
    tbl[3] = '{0, 0, 0, 2'd0, 3'd0, 1, 58, 4, 58, 0, 1};
    tbl[4] = '{0, 1, 1, 2'd0, 3'd2, 1, 59, 5, 59, 2, 1};
    tbl[5] = '{1, 0, 0, 2'd3, 3'd6, 1, 58, 4, 60, 6, 1};

    idle_inputs();
    continue_draw = 0;
    reset_n = 0;
    @(posedge clk); #1;
    step(); step();
    chk("reset_y_base", int'(y_base), 58);
    chk("reset_plot", int'(plot), 0);
    chk("reset_x_out", int'(x_out), 0);
    chk("reset_y_out", int'(y_out), 0);
    chk("reset_draw_enable", int'(draw_enable), 0);
    reset_n = 1;

    // Free-running frame pulses
    continue_draw = 1;
    d0 = de_seen; first_de = -1; gap = -1;
    for (int i = 0; i < 32; i++) begin
      #1;
      if (draw_enable === 1'b1) begin
        if (first_de < 0) first_de = i;
        else if (gap < 0) gap = i - first_de;
      end
      step();
    end
    chk("tick_pulse_count", de_seen - d0, 3);
    chk("tick_period", gap, 8);
    chk("idle_y_base", int'(y_base), 58);

    // Table of single-cycle moves and pixels
    for (int i = 0; i < 6; i++) begin
      y_pos_mod = tbl[i].p; y_neg_mod = tbl[i].n; add_x = tbl[i].ax;
      add_y = tbl[i].ay; colour_in = tbl[i].col; write_en = tbl[i].we;
      step();
      chk($sformatf("vec%0d_y_base", i), int'(y_base), tbl[i].yb);
      chk($sformatf("vec%0d_x_out", i), int'(x_out), tbl[i].x);
      chk($sformatf("vec%0d_y_out", i), int'(y_out), tbl[i].y);
      chk($sformatf("vec%0d_colour", i), int'(colour_out), tbl[i].c);
      chk($sformatf("vec%0d_plot", i), int'(plot), tbl[i].pl);
    end
    idle_inputs();

    // Clamping at both limits and with both strobes
    y_pos_mod = 1;
    for (int i = 0; i < 62; i++) step();
    chk("limit_top", int'(y_base), 0);
    y_pos_mod = 0; y_neg_mod = 1;
    for (int i = 0; i < 125; i++) step();
    chk("limit_bottom", int'(y_base), 117);
    add_y = 3; step();
    chk("limit_bottom_y_out", int'(y_out), 119);
    y_pos_mod = 1; step(); step();
    chk("both_strobes", int'(y_base), 117);
    idle_inputs();

    // Deferred tick while the FSM is busy
    reset_n = 0; step(); reset_n = 1;
    continue_draw = 0;
    d0 = de_seen;
    for (int i = 0; i < 11; i++) step();
    chk("deferred_no_pulse", de_seen - d0, 0);
    continue_draw = 1;
    d0 = de_seen;
    for (int i = 0; i < 3; i++) step();
    chk("deferred_one_pulse", de_seen - d0, 1);

    // Reset in the middle of a pixel burst with a tick outstanding
    continue_draw = 0;
    for (int i = 0; i < 10 && m_pend == 0; i++) step();
    chk("burst_pending_set", m_pend, 1);
    write_en = 1;
    for (int i = 0; i < 3; i++) begin
      add_x = i[0]; add_y = 2'(i); colour_in = 3'd7;
      step();
    end
    reset_n = 0; step();
    chk("midburst_plot", int'(plot), 0);
    chk("midburst_y_base", int'(y_base), 58);
    reset_n = 1; idle_inputs(); continue_draw = 1;
    #1;
    chk("midburst_pending_cleared", int'(draw_enable), 0);
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset_n       = ($urandom_range(0, 99) != 0);
      y_pos_mod     = $urandom_range(0, 1);
      y_neg_mod     = $urandom_range(0, 2) == 0;
      add_x         = $urandom_range(0, 1);
      add_y         = 2'($urandom_range(0, 3));
      colour_in     = 3'($urandom_range(0, 7));
      write_en      = $urandom_range(0, 1);
      continue_draw = $urandom_range(0, 3) != 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
